// File: rtl/spi_arb.sv
// Two-requester round-robin arbiter and command sequencer for the inertial-sensor SPI master.
// Issues one 16-bit command per grant, returns read data, aborts on timeout, supports bounded locked bursts.
module spi_arb #(
    parameter int TMO       = 600,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        lck0,
    input  logic        lck1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [15:0] rsp,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd
);

    localparam int CW = $clog2(TMO + 1);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] TMO_CNT   = CW'(TMO);
    localparam logic [BW-1:0] BURST_TOP = BW'(MAX_BURST - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic          owner;
    logic          last;
    logic [CW-1:0] tmo_cnt;
    logic [BW-1:0] burst_cnt;

    logic          pick;
    logic          own_req;
    logic          own_lck;
    logic          oth_req;
    logic [15:0]   own_cmd;
    logic          keep;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        // On a tie the requester not served last wins; otherwise whoever is asking.
        pick    = (req0 && req1) ? ~last : req1;
        own_req = owner ? req1 : req0;
        own_lck = owner ? lck1 : lck0;
        oth_req = owner ? req0 : req1;
        own_cmd = owner ? cmd1 : cmd0;
        keep    = own_lck && own_req && !(oth_req && (burst_cnt == BURST_TOP));
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            tmo_cnt   <= '0;
            burst_cnt <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            wrt       <= 1'b0;
            rsp       <= 16'h0000;
            cmd       <= 16'h0000;
        end else begin
            wrt   <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        cmd       <= pick ? cmd1 : cmd0;
                        tmo_cnt   <= '0;
                        burst_cnt <= '0;
                        wrt       <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (spi_done) begin
                        rsp   <= spi_rd;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= DONE;
                    end else if (tmo_cnt == TMO_CNT) begin
                        rsp   <= 16'hFFFF;
                        err   <= 1'b1;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (keep) begin
                        cmd     <= own_cmd;
                        wrt     <= 1'b1;
                        tmo_cnt <= '0;
                        if (burst_cnt != BURST_TOP)
                            burst_cnt <= burst_cnt + 1'b1;
                        state   <= ISSUE;
                    end else begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus a randomized transaction stream,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_spi_arb;

    localparam int TMO       = 20;
    localparam int MAX_BURST = 4;

    logic        clk;
    logic        rst;
    logic        req0, req1, lck0, lck1;
    logic [15:0] cmd0, cmd1;
    logic        gnt0, gnt1, done0, done1, err, wrt;
    logic [15:0] rsp, cmd;
    logic        spi_done;
    logic [15:0] spi_rd;

    spi_arb #(.TMO(TMO), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lck0(lck0), .lck1(lck1),
        .cmd0(cmd0), .cmd1(cmd1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rsp(rsp), .wrt(wrt), .cmd(cmd),
        .spi_done(spi_done), .spi_rd(spi_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: last served requester, locked transactions so far in this grant, held response.
    int          m_last;
    int          m_burst;
    logic [15:0] m_rsp;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ctl();
        return {10'b0, gnt0, gnt1, wrt, done0, done1, err};
    endfunction

    function automatic logic [15:0] exp_ctl(input int own, input bit w, input bit d, input bit e);
        logic [15:0] r;
        r    = '0;
        r[5] = (own == 0);
        r[4] = (own == 1);
        r[3] = w;
        r[2] = d && (own == 0);
        r[1] = d && (own == 1);
        r[0] = e;
        return r;
    endfunction

    function automatic int pick_model();
        if (req0 && req1) return 1 - m_last;
        return req1 ? 1 : 0;
    endfunction

    always @(negedge clk)
        if (rst === 1'b0) check("gnt_excl", {15'b0, gnt0 & gnt1}, 16'h0000);

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lck0 = 1'b0; lck1 = 1'b0;
        spi_done = 1'b0;
        tick();
        check("rst_ctl", ctl(), 16'h0000);
        check("rst_rsp", rsp, 16'h0000);
        check("rst_cmd", cmd, 16'h0000);
        rst = 1'b0;
        m_last = 1; m_burst = 0; m_rsp = 16'h0000;
    endtask

    // Idle cycles with random stray completions, which must never disturb anything.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            spi_done = 1'($urandom_range(0, 1));
            spi_rd   = 16'($urandom);
            tick();
            spi_done = 1'b0;
            check("idle_ctl", ctl(), 16'h0000);
            check("idle_rsp", rsp, m_rsp);
        end
    endtask

    // Entered on the ISSUE cycle; leaves the bench on the DONE cycle. lat<0 means no completion.
    task automatic txn(input int own, input int lat, input logic [15:0] data);
        logic [15:0] exp_cmd;
        exp_cmd = (own == 1) ? cmd1 : cmd0;
        check("issue_ctl", ctl(), exp_ctl(own, 1, 0, 0));
        check("issue_cmd", cmd, exp_cmd);
        spi_done = 1'($urandom_range(0, 1));
        spi_rd   = 16'($urandom);
        tick();
        spi_done = 1'b0;
        for (int i = 0; i <= TMO; i++) begin
            check("wait_ctl", ctl(), exp_ctl(own, 0, 0, 0));
            if (i == 0) check("wait_rsp", rsp, m_rsp);
            if (i == lat) begin
                spi_done = 1'b1;
                spi_rd   = data;
            end
            tick();
            spi_done = 1'b0;
            if (i == lat) break;
        end
        m_rsp = (lat < 0) ? 16'hFFFF : data;
        check("done_ctl", ctl(), exp_ctl(own, 0, 1, lat < 0));
        check("done_rsp", rsp, m_rsp);
        check("done_cmd", cmd, exp_cmd);
    endtask

    task automatic set_reqs(input bit r0, input bit l0, input bit r1, input bit l1);
        if (r0 && !req0) cmd0 = 16'($urandom);
        if (r1 && !req1) cmd1 = 16'($urandom);
        req0 = r0; lck0 = l0; req1 = r1; lck1 = l1;
    endtask

    // Called on the DONE cycle: applies next request levels, predicts burst continuation or release.
    task automatic finish_done(input bit r0, input bit l0, input bit r1, input bit l1,
                               input int own, output bit cont);
        bit o_req, o_lck, x_req;
        set_reqs(r0, l0, r1, l1);
        o_req = (own == 1) ? r1 : r0;
        o_lck = (own == 1) ? l1 : l0;
        x_req = (own == 1) ? r0 : r1;
        cont  = o_lck && o_req && !(x_req && (m_burst >= MAX_BURST - 1));
        spi_done = 1'($urandom_range(0, 1));
        spi_rd   = 16'($urandom);
        tick();
        spi_done = 1'b0;
        if (cont) begin
            m_burst++;
        end else begin
            m_last  = own;
            m_burst = 0;
            check("release_ctl", ctl(), 16'h0000);
            check("release_rsp", rsp, m_rsp);
        end
    endtask

    // Called on an IDLE cycle; returns on the ISSUE cycle of the next grant.
    task automatic grant_next(output int own);
        int n;
        int pat;
        if (!req0 && !req1) begin
            n = $urandom_range(0, 3);
            idle_cycles(n);
            pat = $urandom_range(1, 3);
            set_reqs(pat[0], 1'($urandom_range(0, 1)), pat[1], 1'($urandom_range(0, 1)));
        end
        own = pick_model();
        m_burst = 0;
        tick();
    endtask

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return -1;
        if (r == 1) return TMO;
        return $urandom_range(0, 6);
    endfunction

    initial begin
        bit cont;
        int own;
        bit kx;
        bit r0, r1;

        cmd0 = 16'h0; cmd1 = 16'h0; spi_rd = 16'h0;
        do_reset();

        // Single request, completion three cycles after wrt.
        tick();
        set_reqs(1, 0, 0, 0);
        cmd0 = 16'hA5A5;
        tick();
        txn(0, 2, 16'h1234);
        finish_done(0, 0, 0, 0, 0, cont);

        // Tie from reset alternates 0,1,0,1.
        do_reset();
        set_reqs(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            txn(i % 2, $urandom_range(0, 4), 16'($urandom));
            if (i == 3) finish_done(0, 0, 0, 0, i % 2, cont);
            else        finish_done(1, 0, 1, 0, i % 2, cont);
        end

        // Locked burst against a waiting requester 1: four transactions, then requester 1.
        do_reset();
        set_reqs(1, 1, 0, 0);
        tick();
        set_reqs(1, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            txn(0, $urandom_range(0, 3), 16'($urandom));
            finish_done(1, 1, 1, 0, 0, cont);
        end
        tick();
        txn(1, 1, 16'($urandom));
        finish_done(1, 0, 0, 0, 1, cont);
        tick();
        txn(0, 0, 16'($urandom));
        finish_done(0, 0, 0, 0, 0, cont);

        // Locked burst with no competition keeps the grant for ten transactions.
        set_reqs(1, 1, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            txn(0, $urandom_range(0, 2), 16'($urandom));
            finish_done(k < 9, 1, 0, 0, 0, cont);
        end

        // Timeout, then a late completion in IDLE is ignored.
        set_reqs(1, 0, 0, 0);
        tick();
        txn(0, -1, 16'h0000);
        finish_done(0, 0, 0, 0, 0, cont);
        spi_done = 1'b1;
        spi_rd   = 16'h5A5A;
        tick();
        spi_done = 1'b0;
        check("late_ctl", ctl(), 16'h0000);
        check("late_rsp", rsp, 16'hFFFF);

        // Completion on the exact timeout cycle wins.
        set_reqs(0, 0, 1, 0);
        tick();
        txn(1, TMO, 16'hBEEF);
        finish_done(0, 0, 0, 0, 1, cont);

        // Request dropped mid-transaction still completes and releases.
        set_reqs(1, 0, 0, 0);
        tick();
        req0 = 1'b0;
        txn(0, 1, 16'h0F0F);
        finish_done(0, 0, 0, 0, 0, cont);

        // Reset during WAIT, then a fresh requester-1 grant with a single wrt.
        set_reqs(1, 0, 0, 0);
        tick();
        check("pre_rst_wrt", {15'b0, wrt}, 16'h0001);
        tick();
        tick();
        do_reset();
        idle_cycles(3);
        set_reqs(0, 0, 1, 0);
        tick();
        txn(1, 3, 16'h7E57);
        finish_done(0, 0, 0, 0, 1, cont);

        // Randomized transaction stream.
        cont = 1'b0;
        own  = 0;
        for (int it = 0; it < 80; it++) begin
            if (!cont) grant_next(own);
            txn(own, rand_lat(), 16'($urandom));
            kx = ($urandom_range(0, 3) != 0);
            if (own == 0) begin
                r0 = kx;
                r1 = req1 || ($urandom_range(0, 1) == 1);
            end else begin
                r1 = kx;
                r0 = req0 || ($urandom_range(0, 1) == 1);
            end
            finish_done(r0, 1'($urandom_range(0, 1)), r1, 1'($urandom_range(0, 1)), own, cont);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
# spi_arb

Two-requester arbiter and transaction sequencer for the single SPI master that talks to the inertial sensor. Requester 0 is the inertial-interface reader (ptch/roll/yaw reads, calibration reads). Requester 1 is an auxiliary configuration/telemetry client. The block grants the bus round-robin, issues one 16-bit SPI command per grant, returns the read data, and enforces a completion timeout. It supports bounded locked bursts so a requester can read multi-byte registers back-to-back.

## Interface
Parameters:
- TMO, 600: cycles in WAIT before a transaction is aborted; counter width is $clog2(TMO+1).
- MAX_BURST, 4: maximum consecutive locked transactions per grant when the other requester is waiting.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  request. Held high until the matching doneX.
- lck0, lck1  in  1  keep grant after the current transaction (burst). Sampled in DONE.
- cmd0, cmd1  in  16  SPI command word. Must be stable while reqX is high.
- gnt0, gnt1  out  1  bus ownership; at most one high.
- done0, done1  out  1  one-cycle completion pulse to the owner.
- err  out  1  one-cycle pulse coincident with doneX when the transaction timed out.
- rsp  out  16  response word; valid from doneX until the next DONE.
- wrt  out  1  one-cycle start pulse to the SPI master.
- cmd  out  16  latched command to the SPI master; held from ISSUE until the next latch.
- spi_done  in  1  SPI master transaction-complete pulse.
- spi_rd  in  16  SPI master read data; valid with spi_done.

## Operation
- State machine:
  - IDLE: evaluate req0/req1. Move to ISSUE if either is high.
  - ISSUE (1 cycle): wrt=1, then WAIT.
  - WAIT: count cycles. On spi_done, go to DONE. On count==TMO with no spi_done, go to DONE with the error flag set.
  - DONE (1 cycle): doneX=1 and err=error flag, then IDLE or ISSUE (see below).
- Arbitration in IDLE:
  - If only one requester is high, grant it.
  - If both are high, grant the requester not served last (pointer `last`). After reset, `last`=1, so requester 0 wins the first tie.
- On the grant edge (IDLE→ISSUE): register owner, gntX←1, cmd←cmdX, clear the timeout counter and burst counter, clear the error flag.
- On spi_done in WAIT: rsp←spi_rd.
- On timeout: rsp←16'hFFFF, error flag←1.
- DONE exit:
  - If lckX && reqX && !(other req && burst_cnt==MAX_BURST-1): stay owner, cmd←cmdX, burst_cnt+1, go to ISSUE.
  - Otherwise: gntX←0, last←owner, go to IDLE.
- Locked bursts are unlimited while the other requester is idle. The burst counter saturates.
- spi_done in IDLE, ISSUE or DONE is ignored; rsp is unchanged and no pulse is produced.
- spi_done in the same cycle the count reaches TMO: the completion wins and err stays 0.
- reqX dropping mid-transaction does not abort it; doneX still pulses and the grant is released in DONE.
- rst mid-transaction: returns to IDLE the next cycle with all outputs 0. No wrt is reissued. last←1.

## Timing
- Reset values: gnt0=gnt1=0, done0=done1=0, err=0, wrt=0, rsp=16'h0000, cmd=16'h0000, state IDLE, last=1.
- Request seen high in IDLE at cycle 0:
  - cycle 1: gntX=1, wrt=1, cmd valid.
  - cycle 2 onward: WAIT.
- spi_done at cycle k:
  - cycle k+1: doneX=1 and rsp valid.
  - cycle k+2: either gntX=0 (IDLE), or wrt=1 with the new cmd (locked burst).
- Minimum transaction with no lock, spi_done in the first WAIT cycle: 4 cycles from request to grant release. Back-to-back requests from the other requester get wrt 2 cycles after the previous doneX.
- Timeout: with wrt at cycle 1, err and doneX pulse at cycle TMO+3.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Single request: req0=1, cmd0=16'hA5A5, spi_done with spi_rd=16'h1234 three cycles after wrt.
  - Required: gnt0 and wrt rise 1 cycle after req0, and cmd=16'hA5A5.
  - Required: done0 pulses 1 cycle after spi_done, with rsp=16'h1234 and err=0.
  - Required: gnt0=0 on the following cycle.
- Tie and round-robin: req0=req1=1 from reset.
  - Required: grant order is 0, 1, 0, 1 over 4 transactions, and gnt0 and gnt1 are never high together.
- Locked burst with fairness: lck0=1, req0=1 continuous, req1 raised during the first transaction, MAX_BURST=4.
  - Required: exactly 4 requester-0 wrt pulses, then gnt1.
  - Repeat with req1=0: requester 0 keeps the grant indefinitely (check 10 transactions).
- Timeout: TMO=20, spi_done never asserted.
  - Required: done0 and err pulse together 23 cycles after the request edge, with rsp=16'hFFFF.
  - Then a late spi_done in IDLE produces no pulse and rsp is unchanged.
- Boundary: spi_done asserted in the exact cycle the count reaches TMO.
  - Required: err=0 and rsp=spi_rd.
- Reset mid-transaction: assert rst during WAIT.
  - Required: the next cycle shows all outputs 0.
  - Required: a fresh req1 after release is granted 1 cycle after it is sampled, with a single wrt.
